// File: rtl/branch_pc_if.sv
// Interface between the ID stage and the branch/PC unit.
// ID side (master) presents the resolved branch/jump and stall information;
// the PC unit (slave) returns the fetch address, flush and redirect status.
// The optional statistics ports exist only when BRANCH_PC_STATS_EN is defined.
interface branch_pc_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] shift_out;
    logic             branch_take;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc;
    logic             flush;
    logic             redirect;
    logic [WIDTH-1:0] last_target;
`ifdef BRANCH_PC_STATS_EN
    logic [15:0]      taken_count;
    logic [15:0]      jump_count;
`endif

    modport master (
        output stall, id_pc, shift_out, branch_take, jump, jump_target,
        input  pc, flush, redirect, last_target
`ifdef BRANCH_PC_STATS_EN
        , input taken_count, jump_count
`endif
    );

    modport slave (
        input  stall, id_pc, shift_out, branch_take, jump, jump_target,
        output pc, flush, redirect, last_target
`ifdef BRANCH_PC_STATS_EN
        , output taken_count, jump_count
`endif
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter owner for the 16-bit pipeline.
// Computes the PC-relative branch target from the ID-stage shifter output,
// redirects fetch on taken branches and jumps, and raises a registered flush
// for FLUSH_CYCLES unstalled cycles to squash wrong-path instructions.
// Optional feature macro: BRANCH_PC_STATS_EN adds saturating counters of
// accepted branch and jump redirects (taken_count / jump_count).
module branch_pc_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               PC_STEP      = 2,
    parameter int               FLUSH_CYCLES = 1
) (
    input logic        clk,
    input logic        rst,
    branch_pc_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t           state_q;
    logic [2:0]       count_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] last_q;
    logic             flush_q;
    logic             redirect_q;

    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] pc_seq;
    logic             accept_jump;
    logic             accept_branch;

    // Target and sequential-address arithmetic; both wrap modulo 2^WIDTH.
    assign br_tgt = bus.id_pc + STEP + bus.shift_out;
    assign pc_seq = pc_q + STEP;

    // A redirect is only honoured while fetching normally and not stalled;
    // jump wins over a simultaneous taken branch.
    assign accept_jump   = (state_q == RUN) && !bus.stall && bus.jump;
    assign accept_branch = (state_q == RUN) && !bus.stall && !bus.jump && bus.branch_take;

    // Fetch/flush state machine with registered pc, flush, redirect and last_target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            count_q    <= 3'd0;
            pc_q       <= RESET_PC;
            last_q     <= '0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (accept_jump) begin
                        pc_q       <= bus.jump_target;
                        last_q     <= bus.jump_target;
                        state_q    <= FLUSH;
                        count_q    <= FLUSH_LOAD;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                    end else if (accept_branch) begin
                        pc_q       <= br_tgt;
                        last_q     <= br_tgt;
                        state_q    <= FLUSH;
                        count_q    <= FLUSH_LOAD;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                    end else if (!bus.stall) begin
                        pc_q <= pc_seq;
                    end
                end
                FLUSH: begin
                    if (!bus.stall) begin
                        pc_q    <= pc_seq;
                        count_q <= count_q - 3'd1;
                        if (count_q <= 3'd1) begin
                            state_q <= RUN;
                            flush_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.flush       = flush_q;
    assign bus.redirect    = redirect_q;
    assign bus.last_target = last_q;

`ifdef BRANCH_PC_STATS_EN
    logic [15:0] taken_q;
    logic [15:0] jumps_q;

    // Saturating counts of accepted branch and jump redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q <= 16'd0;
            jumps_q <= 16'd0;
        end else begin
            if (accept_branch && (taken_q != 16'hFFFF)) begin
                taken_q <= taken_q + 16'd1;
            end
            if (accept_jump && (jumps_q != 16'hFFFF)) begin
                jumps_q <= jumps_q + 16'd1;
            end
        end
    end

    assign bus.taken_count = taken_q;
    assign bus.jump_count  = jumps_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Testbench for branch_pc_unit: directed vector table, hand-written
// multi-cycle sequences (stall inside flush, reset mid-flush) and a
// randomized phase checked against a behavioural reference model.
// Honours BRANCH_PC_STATS_EN when defined.
module tb_branch_pc_unit;

    localparam int WIDTH = 16;
    localparam int STEP  = 2;
    localparam int FC    = 2;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_last;
    int          m_flush_left;
    logic        m_redirect;
    int          m_taken;
    int          m_jumps;

    always #5 clk = ~clk;

    branch_pc_if #(.WIDTH(WIDTH)) bus ();

    branch_pc_unit #(
        .WIDTH        (WIDTH),
        .RESET_PC     (16'h0000),
        .PC_STEP      (STEP),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        jump;
        logic [15:0] id_pc;
        logic [15:0] shift_out;
        logic [15:0] jump_target;
        logic [15:0] exp_pc;
        logic        exp_flush;
        logic        exp_redirect;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs [22];

    // Model: a redirect loads the target and opens a flush window of FC
    // unstalled cycles; everything else is a wrapping +STEP fetch.
    function automatic void modelStep(input logic r, input logic s, input logic b,
                                      input logic j, input logic [15:0] ipc,
                                      input logic [15:0] sh, input logic [15:0] jt);
        int tgt;
        if (r) begin
            m_pc = 16'h0000; m_last = 16'h0000; m_flush_left = 0;
            m_redirect = 1'b0; m_taken = 0; m_jumps = 0;
            return;
        end
        m_redirect = 1'b0;
        if (m_flush_left > 0) begin
            if (!s) begin
                m_pc = 16'((int'(m_pc) + STEP) % 65536);
                m_flush_left = m_flush_left - 1;
            end
        end else if (!s) begin
            if (j) begin
                m_pc = jt; m_last = jt; m_flush_left = FC; m_redirect = 1'b1;
                if (m_jumps < 65535) m_jumps = m_jumps + 1;
            end else if (b) begin
                tgt = (int'(ipc) + STEP + int'(sh)) % 65536;
                m_pc = 16'(tgt); m_last = 16'(tgt); m_flush_left = FC; m_redirect = 1'b1;
                if (m_taken < 65535) m_taken = m_taken + 1;
            end else begin
                m_pc = 16'((int'(m_pc) + STEP) % 65536);
            end
        end
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic j, input logic [15:0] ipc,
                                 input logic [15:0] sh, input logic [15:0] jt);
        rst             = r;
        bus.stall       = s;
        bus.branch_take = b;
        bus.jump        = j;
        bus.id_pc       = ipc;
        bus.shift_out   = sh;
        bus.jump_target = jt;
        @(posedge clk);
        modelStep(r, s, b, j, ipc, sh, jt);
        #1;
    endtask

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] e_pc, input logic e_flush,
                               input logic e_redirect, input logic [15:0] e_last);
        checkField({tag, ".pc"}, bus.pc, e_pc);
        checkField({tag, ".flush"}, 16'(bus.flush), 16'(e_flush));
        checkField({tag, ".redirect"}, 16'(bus.redirect), 16'(e_redirect));
        checkField({tag, ".last_target"}, bus.last_target, e_last);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_pc, (m_flush_left > 0), m_redirect, m_last);
`ifdef BRANCH_PC_STATS_EN
        checkField({tag, ".taken_count"}, bus.taken_count, 16'(m_taken));
        checkField({tag, ".jump_count"}, bus.jump_count, 16'(m_jumps));
`endif
    endtask

    task automatic checkStats(input string tag, input logic [15:0] e_taken, input logic [15:0] e_jumps);
`ifdef BRANCH_PC_STATS_EN
        checkField({tag, ".taken_count"}, bus.taken_count, e_taken);
        checkField({tag, ".jump_count"}, bus.jump_count, e_jumps);
`else
        if (e_taken == e_jumps) begin end
`endif
    endtask

    initial begin
        logic r, s, b, j;

        rst = 1'b1;
        bus.stall = 1'b0; bus.branch_take = 1'b0; bus.jump = 1'b0;
        bus.id_pc = '0; bus.shift_out = '0; bus.jump_target = '0;

        // Directed table (FC = 2): reset, free run, branches, wrap, jump priority, stall
        vecs[0]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000};
        vecs[1]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000};
        vecs[2]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 0, 0, 16'h0000};
        vecs[3]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 0, 0, 16'h0000};
        vecs[4]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 0, 0, 16'h0000};
        vecs[5]  = '{0, 0, 1, 0, 16'h0010, 16'h0014, 16'h0000, 16'h0026, 1, 1, 16'h0026};
        vecs[6]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0028, 1, 0, 16'h0026};
        vecs[7]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h002A, 0, 0, 16'h0026};
        vecs[8]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h002C, 0, 0, 16'h0026};
        vecs[9]  = '{0, 0, 1, 0, 16'h0002, 16'hFFF8, 16'h0000, 16'hFFFC, 1, 1, 16'hFFFC};
        vecs[10] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 1, 0, 16'hFFFC};
        vecs[11] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'hFFFC};
        vecs[12] = '{0, 0, 1, 0, 16'h0002, 16'hFFF6, 16'h0000, 16'hFFFA, 1, 1, 16'hFFFA};
        vecs[13] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFC, 1, 0, 16'hFFFA};
        vecs[14] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 0, 0, 16'hFFFA};
        vecs[15] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'hFFFA};
        vecs[16] = '{0, 0, 1, 1, 16'h0010, 16'h0014, 16'h0100, 16'h0100, 1, 1, 16'h0100};
        vecs[17] = '{0, 0, 1, 0, 16'h0010, 16'h0014, 16'h0000, 16'h0102, 1, 0, 16'h0100};
        vecs[18] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0200, 16'h0104, 0, 0, 16'h0100};
        vecs[19] = '{0, 1, 1, 0, 16'h0010, 16'h0014, 16'h0000, 16'h0104, 0, 0, 16'h0100};
        vecs[20] = '{0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0300, 16'h0104, 0, 0, 16'h0100};
        vecs[21] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0106, 0, 0, 16'h0100};

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].jump,
                          vecs[i].id_pc, vecs[i].shift_out, vecs[i].jump_target);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_flush,
                        vecs[i].exp_redirect, vecs[i].exp_last);
        end

        // Stall held for 3 cycles inside the flush window
        applyStimulus(0, 0, 1, 0, 16'h0040, 16'h0000, 16'h0000);
        checkOutput("stall_br", 16'h0042, 1, 1, 16'h0042);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 1, 16'h0100, 16'h0010, 16'h0700);
            checkOutput($sformatf("stall_hold%0d", i), 16'h0042, 1, 0, 16'h0042);
        end
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("stall_rel1", 16'h0044, 1, 0, 16'h0042);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("stall_rel2", 16'h0046, 0, 0, 16'h0042);

        // Reset in the second flush cycle after one branch and one jump
        applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("mid_rst0", 16'h0000, 0, 0, 16'h0000);
        checkStats("mid_rst0", 16'd0, 16'd0);
        applyStimulus(0, 0, 1, 0, 16'h0010, 16'h0004, 16'h0000);
        checkOutput("mid_br", 16'h0016, 1, 1, 16'h0016);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("mid_run", 16'h001A, 0, 0, 16'h0016);
        applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0500);
        checkOutput("mid_jmp", 16'h0500, 1, 1, 16'h0500);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("mid_fl2", 16'h0502, 1, 0, 16'h0500);
        checkStats("mid_pre", 16'd1, 16'd1);
        applyStimulus(1, 0, 1, 1, 16'h0010, 16'h0004, 16'h0900);
        checkOutput("mid_rst", 16'h0000, 0, 0, 16'h0000);
        checkStats("mid_rst", 16'd0, 16'd0);
        applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        checkOutput("mid_after", 16'h0002, 0, 0, 16'h0000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 30);
            j = ($urandom_range(0, 99) < 12);
            applyStimulus(r, s, b, j, 16'($urandom), 16'($urandom), 16'($urandom));
            checkModel($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
